// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grant, execute, respond.
// Arbitration policy: define ALU_ARB_RR_EN for round-robin, otherwise req0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             zero_flag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             grant_valid_s;
    logic             grant_id_s;
`ifdef ALU_ARB_RR_EN
    logic             rr_ptr_q, rr_ptr_d;
`endif

    // Grant selection; gated by rst_n so ready stays low while reset is held
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            grant_valid_s = req0_valid | req1_valid;
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
                grant_id_s = rr_ptr_q;
`else
                grant_id_s = 1'b0;
`endif
            end else if (req1_valid) begin
                grant_id_s = 1'b1;
            end else begin
                grant_id_s = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_ARB_RR_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    a_d     = grant_id_s ? req1_a  : req0_a;
                    b_d     = grant_id_s ? req1_b  : req0_b;
                    op_d    = grant_id_s ? req1_op : req0_op;
                    id_d    = grant_id_s;
                    state_d = EXEC;
`ifdef ALU_ARB_RR_EN
                    rr_ptr_d = ~grant_id_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = zero_flag;
                state_d  = RESP;
            end
            RESP: begin
                if (id_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            op_q     <= 3'b000;
            id_q     <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Round-robin pointer: names the requester that wins the next contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Output decode; ALU drive is zero outside EXEC
    always_comb begin
        req0_ready = grant_valid_s & ~grant_id_s;
        req1_ready = grant_valid_s & grant_id_s;
        rsp0_valid = (state_q == RESP) & ~id_q;
        rsp1_valid = (state_q == RESP) & id_q;
        busy       = (state_q != IDLE);
        rsp_result = result_q;
        rsp_zero   = zero_q;
        if (state_q == EXEC) begin
            alu_in_a    = a_q;
            alu_in_b    = b_q;
            alu_control = op_q;
        end else begin
            alu_in_a    = {WIDTH{1'b0}};
            alu_in_b    = {WIDTH{1'b0}};
            alu_control = 3'b000;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic [2:0]  req0_op = 3'b000, req1_op = 3'b000;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [31:0] alu_in_a, alu_in_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_control(alu_control),
        .alu_result(alu_result), .zero_flag(zero_flag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: and, or, add, sub, slt
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_in_a & alu_in_b;
            3'b001:  alu_result = alu_in_a | alu_in_b;
            3'b010:  alu_result = alu_in_a + alu_in_b;
            3'b110:  alu_result = alu_in_a - alu_in_b;
            3'b111:  alu_result = ($signed(alu_in_a) < $signed(alu_in_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
        zero_flag = (alu_result == 32'd0);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        checks++;
        if ({rsp_result, rsp_zero, alu_in_a, alu_in_b, alu_control} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data: result %0d zero %b alu_a %0d alu_b %0d ctl %b, expected all zero",
                     rsp_result, rsp_zero, alu_in_a, alu_in_b, alu_control);
        end
        req0_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_a = 32'd23; req0_b = 32'd40; req0_op = 3'b010;
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b100) begin
            errors++;
            $display("FAIL add_accept: ready0/ready1/busy got %b expected 100", {req0_ready, req1_ready, busy});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 32'd7; req0_b = 32'd7; req0_op = 3'b110;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b00001) begin
            errors++;
            $display("FAIL add_exec_ctrl: got %b expected 00001", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        checks++;
        if (alu_in_a !== 32'd23 || alu_in_b !== 32'd40 || alu_control !== 3'b010) begin
            errors++;
            $display("FAIL add_exec_alu: a %0d b %0d ctl %b expected 23 40 010", alu_in_a, alu_in_b, alu_control);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b101 || rsp_result !== 32'd63 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: valid0/valid1/busy %b result %0d zero %b expected 101 63 0",
                     {rsp0_valid, rsp1_valid, busy}, rsp_result, rsp_zero);
        end
        checks++;
        if (alu_in_a !== 32'd0 || alu_control !== 3'b000) begin
            errors++;
            $display("FAIL add_resp_alu_idle: a %0d ctl %b expected 0 000", alu_in_a, alu_control);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp0_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL add_done: valid0/busy got %b expected 00", {rsp0_valid, busy});
        end
    endtask

    task automatic test_sub();
        logic [31:0] av [2] = '{32'd42, 32'd23};
        logic [31:0] bv [2] = '{32'd23, 32'd23};
        logic [31:0] rv [2] = '{32'd19, 32'd0};
        logic        zv [2] = '{1'b0, 1'b1};
        rsp1_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req1_valid = 1'b1; req1_a = av[i]; req1_b = bv[i]; req1_op = 3'b110;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b01) begin
                errors++;
                $display("FAIL sub%0d_accept: ready0/ready1 got %b expected 01", i, {req0_ready, req1_ready});
            end
            @(posedge clk); #1;
            req1_valid = 1'b0; req1_a = 32'd1000; req1_b = 32'd1; req1_op = 3'b000;
            @(posedge clk); #1;
            checks++;
            if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_result !== rv[i] || rsp_zero !== zv[i]) begin
                errors++;
                $display("FAIL sub%0d_resp: valid0/valid1 %b result %0d zero %b expected 01 %0d %b",
                         i, {rsp0_valid, rsp1_valid}, rsp_result, rsp_zero, rv[i], zv[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        req0_valid = 1'b1; req0_a = 32'd12; req0_b = 32'd10; req0_op = 3'b000;
        rsp0_ready = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready} !== 5'b10100 || rsp_result !== 32'd8) begin
                errors++;
                $display("FAIL stall_hold%0d: valid0/valid1/busy/ready0/ready1 %b result %0d expected 10100 8",
                         i, {rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready}, rsp_result);
            end
        end
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, rsp0_valid, req1_ready} !== 3'b001) begin
            errors++;
            $display("FAIL stall_release: busy/valid0/ready1 got %b expected 001", {busy, rsp0_valid, req1_ready});
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_exec();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b010;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || alu_control !== 3'b010) begin
            errors++;
            $display("FAIL rstexec_pre: busy %b ctl %b expected 1 010", busy, alu_control);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b00000 ||
            alu_in_a !== 32'd0 || alu_control !== 3'b000 || rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL rstexec_async: ctrl %b alu_a %0d ctl %b result %0d expected 00000 0 000 0",
                     {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, alu_in_a, alu_control, rsp_result);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
                errors++;
                $display("FAIL rstexec_after%0d: busy/valid0/valid1 got %b expected 000", i, {busy, rsp0_valid, rsp1_valid});
            end
        end
    endtask

    task automatic test_arbitration();
        int exp_id;
        int n;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_op = 3'b010;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd1; req1_op = 3'b110;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_id = k % 2;
`else
            exp_id = 0;
`endif
            n = 0;
            while (busy === 1'b1 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (n >= 10) begin
                errors++;
                $display("FAIL arb%0d_timeout: busy still %b after %0d cycles expected 0", k, busy, n);
            end
            checks++;
            if ({req0_ready, req1_ready} !== ((exp_id == 1) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL arb%0d_grant: ready0/ready1 got %b expected grant to %0d", k, {req0_ready, req1_ready}, exp_id);
            end
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++;
            if ({rsp0_valid, rsp1_valid} !== ((exp_id == 1) ? 2'b01 : 2'b10) ||
                rsp_result !== ((exp_id == 1) ? 32'd9 : 32'd11)) begin
                errors++;
                $display("FAIL arb%0d_resp: valid0/valid1 %b result %0d expected requester %0d", k,
                         {rsp0_valid, rsp1_valid}, rsp_result, exp_id);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_stall();
        test_reset_exec();
        test_arbitration();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
